// File: rtl/dff16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff16_pkg
// Purpose  : Shared width and reset-value constants for the 16-bit D register.
// Revision : 1.0 - initial release
// ============================================================================
package dff16_pkg;

  localparam int unsigned      DFF16_WIDTH       = 16;
  localparam logic [15:0]      DFF16_RESET_VALUE = 16'h0000;

endpackage : dff16_pkg
`default_nettype wire

// File: rtl/d_flip_flop_1_bit.sv
`default_nettype none
// ============================================================================
// Module   : d_flip_flop_1_bit
// Purpose  : One register bit: a hold/load mux feeding a flop with a
//            synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module d_flip_flop_1_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic LOAD,
  input  wire logic d,
  output logic      q
);

  logic w_next;
  logic r_q;

  // Hold/load mux: LOAD selects the new data, otherwise recirculate.
  always_comb begin
    w_next = r_q;
    if (LOAD) begin
      w_next = d;
    end
  end

  // Storage flop; reset takes priority over any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule : d_flip_flop_1_bit
`default_nettype wire

// File: rtl/d_flip_flop_16_bit.sv
`default_nettype none
// ============================================================================
// Module   : d_flip_flop_16_bit
// Purpose  : WIDTH-bit loadable register with synchronous active-high reset,
//            built from one-bit cells. Q comes straight from flops.
// Options  : DFF16_PARITY_EN - adds registered even-parity output Q_PAR.
// Revision : 1.0 - initial release
// ============================================================================
module d_flip_flop_16_bit
  import dff16_pkg::*;
#(
  parameter int unsigned        WIDTH       = DFF16_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = DFF16_RESET_VALUE
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             LOAD,
  input  wire logic [WIDTH-1:0] D,
`ifdef DFF16_PARITY_EN
  output logic                  Q_PAR,
`endif
  output logic      [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] w_q;

  // One cell per bit, all sharing the single LOAD enable.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    d_flip_flop_1_bit #(
      .RESET_BIT (RESET_VALUE[gi])
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .LOAD (LOAD),
      .d    (D[gi]),
      .q    (w_q[gi])
    );
  end : g_bits

  assign Q = w_q;

`ifdef DFF16_PARITY_EN
  localparam logic c_RESET_PAR = ^RESET_VALUE;

  logic r_par;

  // Parity is computed from D and captured on the same edge as Q, so it
  // always describes the value currently held in Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= c_RESET_PAR;
    end else if (LOAD) begin
      r_par <= ^D;
    end
  end

  assign Q_PAR = r_par;
`endif

endmodule : d_flip_flop_16_bit
`default_nettype wire

// File: tb/tb_d_flip_flop_16_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_flip_flop_16_bit
// Purpose  : Self-checking bench for d_flip_flop_16_bit: directed scenarios
//            plus randomized traffic against a behavioural register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_flip_flop_16_bit;
  import dff16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        LOAD;
  logic [15:0] D;
  logic [15:0] Q;
`ifdef DFF16_PARITY_EN
  logic        Q_PAR;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  logic [15:0] m_q;

  d_flip_flop_16_bit dut (
    .clk   (clk),
    .rst   (rst),
    .LOAD  (LOAD),
    .D     (D),
`ifdef DFF16_PARITY_EN
    .Q_PAR (Q_PAR),
`endif
    .Q     (Q)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check Q
  // against the model 1 time unit after the edge.
  task automatic cycle(input string tag, input logic r, input logic l,
                       input logic [15:0] d);
    rst  = r;
    LOAD = l;
    D    = d;
    @(posedge clk);
    if (r)      m_q = DFF16_RESET_VALUE;
    else if (l) m_q = d;
    #1;
    check_val(tag, Q, m_q);
`ifdef DFF16_PARITY_EN
    check_val({tag, "_par"}, {15'b0, Q_PAR}, {15'b0, ($countones(m_q) % 2 == 1)});
`endif
  endtask

  initial begin
    logic [15:0] d_acc;
    logic [15:0] hold_pat [3];
    hold_pat[0] = 16'h0000;
    hold_pat[1] = 16'h1234;
    hold_pat[2] = 16'hA5A5;
    rst = 1'b0; LOAD = 1'b0; D = 16'h0;
    m_q = 16'h0;
    @(negedge clk);

    // Reset wins over LOAD with all-ones data
    cycle("reset", 1'b1, 1'b1, 16'hFFFF);
    check_val("reset_const", Q, 16'h0000);

    // Walking fill: Q follows D one cycle later through 0x0001..0xFFFF
    d_acc = 16'h0;
    for (int x = 0; x < 16; x++) begin
      d_acc = d_acc | (16'h1 << x);
      cycle("fill", 1'b0, 1'b1, d_acc);
      check_val("fill_const", Q, 16'((17'h1 << (x + 1)) - 17'h1));
    end

    // Hold: LOAD=0, D varies, Q stays 0xFFFF
    for (int c = 0; c < 16; c++) begin
      cycle("hold", 1'b0, 1'b0, hold_pat[c % 3]);
      check_val("hold_const", Q, 16'hFFFF);
    end

    // Mid-cycle D change does not disturb Q before the next edge
    cycle("mid_a", 1'b0, 1'b1, 16'h1234);
    #3 D = 16'h5678;
    #1 check_val("mid_between", Q, 16'h1234);
    @(posedge clk); m_q = 16'h5678; #1;
    check_val("mid_after", Q, 16'h5678);

    // Reset asserted between edges only takes effect at the edge
    #2 rst = 1'b1; LOAD = 1'b0;
    #1 check_val("rst_between", Q, 16'h5678);
    cycle("rst_edge", 1'b1, 1'b0, 16'h0000);

    // Simultaneous reset and load, then normal capture after reset releases
    cycle("rst_load", 1'b1, 1'b1, 16'hBEEF);
    check_val("rst_load_const", Q, 16'h0000);
    cycle("post_rst", 1'b0, 1'b1, 16'hBEEF);
    check_val("post_rst_const", Q, 16'hBEEF);

`ifdef DFF16_PARITY_EN
    // Parity of specific loaded values
    cycle("par1", 1'b0, 1'b1, 16'h0001);
    check_val("par1_const", {15'b0, Q_PAR}, 16'h1);
    cycle("par2", 1'b0, 1'b1, 16'h0003);
    check_val("par2_const", {15'b0, Q_PAR}, 16'h0);
    cycle("par3", 1'b0, 1'b1, 16'h8000);
    check_val("par3_const", {15'b0, Q_PAR}, 16'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_d_flip_flop_16_bit
`default_nettype wire

// File: doc/d_flip_flop_16_bit.md
D_FLIP_FLOP_16_BIT -- requirements
Module: d_flip_flop_16_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: register width in bits; only 16 is required to be supported.
REQ-002 The block SHALL have parameter RESET_VALUE, default 16'h0000: value loaded into Q by reset.
REQ-003 The block SHALL have one clock and a synchronous active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port LOAD, input, 1 bit: write enable; 1 = capture D, 0 = hold.
REQ-007 Port D, input, 16 bits: data to capture.
REQ-008 Port Q, output, 16 bits: registered data; it is driven directly from flops with no combinational path from D or LOAD.

Function
REQ-009 At each rising clk edge with rst=0 and LOAD=1, Q SHALL take the value of D sampled at that edge, so Q shows the new value one cycle after D.
REQ-010 At each rising clk edge with rst=0 and LOAD=0, Q SHALL keep its previous value, whatever D is.
REQ-011 Q SHALL change only at rising clk edges; D or LOAD changing between edges SHALL NOT affect Q.
REQ-012 All 16 bits SHALL be loaded together under the single LOAD; there are no per-bit enables.
REQ-013 The LOAD-to-capture latency SHALL be exactly 1 cycle, and back-to-back LOAD=1 cycles SHALL capture every new D.
REQ-014 An X or Z on LOAD with rst=0 is not a supported input, and the bench SHALL NOT drive it.

Reset
REQ-015 At a rising clk edge with rst=1, Q SHALL become RESET_VALUE (0x0000), regardless of LOAD and D.
REQ-016 If rst and LOAD are both 1 at the same edge, reset SHALL win.
REQ-017 Asserting rst between edges SHALL NOT change Q until the next rising edge.
REQ-018 After rst deasserts, the first edge with LOAD=1 SHALL capture D normally.
REQ-019 Before the first reset edge, the value of Q is undefined.

Configuration
REQ-020 When the macro DFF16_PARITY_EN is defined, the block SHALL add an output port Q_PAR (1 bit) holding the even parity (XOR) of the Q value.
REQ-021 With DFF16_PARITY_EN defined, Q_PAR SHALL be registered alongside Q, so it always matches the current Q.
REQ-022 With DFF16_PARITY_EN defined, Q_PAR SHALL reset to the parity of RESET_VALUE (0 for 0x0000).
REQ-023 When DFF16_PARITY_EN is not defined, Q_PAR and its logic SHALL be absent, and the block's behaviour SHALL be otherwise identical.

Structure
REQ-024 A shared package dff16_pkg SHALL hold the constant DFF16_WIDTH = 16 and the constant DFF16_RESET_VALUE = 16'h0000; the parameters SHALL default to these constants.
REQ-025 A sub-module d_flip_flop_1_bit (ports clk, rst, LOAD, d, q) SHALL implement one bit: a hold/load mux feeding a flop with synchronous reset.
REQ-026 The top level SHALL instantiate WIDTH copies of d_flip_flop_1_bit in a generate loop.
REQ-027 The optional parity register SHALL live in the top level.

Verification
REQ-028 Scenario: rst=1 for one edge with D=0xFFFF and LOAD=1 -> Q=0x0000 (Q_PAR=0).
REQ-029 Scenario: after reset, LOAD=1 and D starts at 0, then bit x of D is set at each cycle for x=0..15 -> Q follows D one cycle later, through 0x0001, 0x0003, ..., 0xFFFF.
REQ-030 Scenario: LOAD=0 after Q=0xFFFF, then D driven 0x0000, 0x1234, 0xA5A5 over 16 cycles -> Q stays 0xFFFF throughout.
REQ-031 Scenario: LOAD=1 with D=0x1234, then D changed to 0x5678 mid-cycle -> Q=0x1234 until the next edge, then 0x5678.
REQ-032 Scenario: LOAD=1, D=0xBEEF and rst=1 at the same edge -> Q=0x0000; next edge with rst=0 -> Q=0xBEEF.
REQ-033 Scenario, with DFF16_PARITY_EN defined: load 0x0001 -> Q_PAR=1; load 0x0003 -> Q_PAR=0; load 0x8000 -> Q_PAR=1.
